// File: rtl/br_result_update_queue.sv
// br_result_update_queue
//
// Collects resolved branch outcomes from the integer execution lanes and
// drains them in resolution order into the PHT write ports of the
// per-address branch predictor. Each stored entry already holds the PHT
// index and the next saturating-counter value, so the predictor side only
// has to write. At most one write per PHT bank (index[0]) is issued per
// cycle; the first bank conflict ends the pop group for that cycle.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   brValid[]        lane carries a resolved branch
//   brAddr[]         branch PC
//   execTaken[]      actual direction
//   mispred[]        prediction was wrong
//   isCondBr[]       conditional branch
//   prevCounter[]    counter value read at predict time
//   pushReady        a full push group fits this cycle
//   updStall         predictor cannot accept writes
//   updValid[]       write port active, entry dequeues at this edge
//   updIndex[]       PHT write address
//   updCounter[]     new counter value
//   updTaken[], updMispred[], updIsCondBr[]  passed through for history repair
//   dropCount        results lost while not ready (saturating)
module br_result_update_queue #(
    parameter int ENTRY_NUM           = 8,
    parameter int PUSH_WIDTH          = 2,
    parameter int POP_WIDTH           = 2,
    parameter int ADDR_WIDTH          = 32,
    parameter int INSN_ADDR_BIT_WIDTH = 2,
    parameter int INDEX_WIDTH         = 10,
    parameter int COUNTER_WIDTH       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     brValid     [PUSH_WIDTH],
    input  logic [ADDR_WIDTH-1:0]    brAddr      [PUSH_WIDTH],
    input  logic                     execTaken   [PUSH_WIDTH],
    input  logic                     mispred     [PUSH_WIDTH],
    input  logic                     isCondBr    [PUSH_WIDTH],
    input  logic [COUNTER_WIDTH-1:0] prevCounter [PUSH_WIDTH],
    output logic                     pushReady,
    input  logic                     updStall,
    output logic                     updValid    [POP_WIDTH],
    output logic [INDEX_WIDTH-1:0]   updIndex    [POP_WIDTH],
    output logic [COUNTER_WIDTH-1:0] updCounter  [POP_WIDTH],
    output logic                     updTaken    [POP_WIDTH],
    output logic                     updMispred  [POP_WIDTH],
    output logic                     updIsCondBr [POP_WIDTH],
    output logic [15:0]              dropCount
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         CNT_ONE = 1;
    localparam logic [COUNTER_WIDTH-1:0] CTR_ONE = 1;
    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX = '1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [15:0]      drop_count;

    logic [INDEX_WIDTH-1:0]   ent_index   [ENTRY_NUM];
    logic [COUNTER_WIDTH-1:0] ent_counter [ENTRY_NUM];
    logic                     ent_taken   [ENTRY_NUM];
    logic                     ent_mispred [ENTRY_NUM];
    logic                     ent_cond    [ENTRY_NUM];

    logic                     push_ready;
    logic [CNT_W-1:0]         valid_num;
    logic [CNT_W-1:0]         push_num;
    logic [PTR_W-1:0]         lane_slot   [PUSH_WIDTH];
    logic [INDEX_WIDTH-1:0]   new_index   [PUSH_WIDTH];
    logic [COUNTER_WIDTH-1:0] new_counter [PUSH_WIDTH];
    logic [16:0]              drop_sum;
    logic [15:0]              drop_next;

    logic [CNT_W-1:0]         pop_num;
    logic                     pop_blocked;
    logic                     lane_ok;
    logic [PTR_W-1:0]         pop_slot;
    logic [PTR_W-1:0]         prev_slot;

    // Upper address bits do not take part in indexing.
    logic                     unused_addr_bits;

    assign pushReady = push_ready;
    assign dropCount = drop_count;

    // Push side. Space is judged on the start-of-cycle count, so pops in
    // the same cycle never make room for pushes. Valid lanes are packed
    // behind the tail in lane order; the running valid count gives each
    // lane its slot, so invalid lanes leave no hole.
    always_comb begin
        push_ready       = !rst && ((ENTRY_NUM - int'(count)) >= PUSH_WIDTH);
        valid_num        = '0;
        unused_addr_bits = 1'b0;
        for (int l = 0; l < PUSH_WIDTH; l++) begin
            lane_slot[l] = tail + valid_num[PTR_W-1:0];
            new_index[l] = brAddr[l][INDEX_WIDTH-1+INSN_ADDR_BIT_WIDTH:INSN_ADDR_BIT_WIDTH];
            if (execTaken[l]) begin
                new_counter[l] = (prevCounter[l] == CTR_MAX) ? prevCounter[l]
                                                             : prevCounter[l] + CTR_ONE;
            end else begin
                new_counter[l] = (prevCounter[l] == '0) ? prevCounter[l]
                                                        : prevCounter[l] - CTR_ONE;
            end
            if (brValid[l]) begin
                valid_num = valid_num + CNT_ONE;
            end
            unused_addr_bits = unused_addr_bits ^ (^brAddr[l]);
        end
        push_num  = push_ready ? valid_num : '0;
        drop_sum  = {1'b0, drop_count} + 17'(valid_num);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Pop side. Lanes are presented straight from the head entries and
    // granted strictly in order: a lane is refused when the queue is too
    // shallow or its bank matches any earlier lane, and a refusal stops all
    // later lanes so the predictor always sees updates in resolution order.
    always_comb begin
        pop_num     = '0;
        pop_blocked = rst || updStall;
        lane_ok     = 1'b0;
        pop_slot    = head;
        prev_slot   = head;
        for (int i = 0; i < POP_WIDTH; i++) begin
            pop_slot       = head + PTR_W'(i);
            updIndex[i]    = ent_index[pop_slot];
            updCounter[i]  = ent_counter[pop_slot];
            updTaken[i]    = ent_taken[pop_slot];
            updMispred[i]  = ent_mispred[pop_slot];
            updIsCondBr[i] = ent_cond[pop_slot];
            lane_ok        = !pop_blocked && (int'(count) > i);
            for (int j = 0; j < i; j++) begin
                prev_slot = head + PTR_W'(j);
                if (ent_index[prev_slot][0] == ent_index[pop_slot][0]) begin
                    lane_ok = 1'b0;
                end
            end
            updValid[i] = lane_ok;
            if (lane_ok) begin
                pop_num = pop_num + CNT_ONE;
            end else begin
                pop_blocked = 1'b1;
            end
        end
    end

    // Pointers wrap naturally at the power-of-two depth. Drops are counted
    // only outside reset, since push_ready is forced low during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            head  <= head + pop_num[PTR_W-1:0];
            tail  <= tail + push_num[PTR_W-1:0];
            count <= count + push_num - pop_num;
            if (!push_ready) begin
                drop_count <= drop_next;
            end
        end
    end

    // Entry storage needs no reset: only slots between head and tail are
    // ever granted.
    always_ff @(posedge clk) begin
        if (push_ready) begin
            for (int l = 0; l < PUSH_WIDTH; l++) begin
                if (brValid[l]) begin
                    ent_index[lane_slot[l]]   <= new_index[l];
                    ent_counter[lane_slot[l]] <= new_counter[l];
                    ent_taken[lane_slot[l]]   <= execTaken[l];
                    ent_mispred[lane_slot[l]] <= mispred[l];
                    ent_cond[lane_slot[l]]    <= isCondBr[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_br_result_update_queue.sv
module tb_br_result_update_queue;

    logic        clk;
    logic        rst;
    logic        brValid     [2];
    logic [31:0] brAddr      [2];
    logic        execTaken   [2];
    logic        mispred     [2];
    logic        isCondBr    [2];
    logic [1:0]  prevCounter [2];
    logic        pushReady;
    logic        updStall;
    logic        updValid    [2];
    logic [9:0]  updIndex    [2];
    logic [1:0]  updCounter  [2];
    logic        updTaken    [2];
    logic        updMispred  [2];
    logic        updIsCondBr [2];
    logic [15:0] dropCount;

    br_result_update_queue dut (
        .clk         (clk),
        .rst         (rst),
        .brValid     (brValid),
        .brAddr      (brAddr),
        .execTaken   (execTaken),
        .mispred     (mispred),
        .isCondBr    (isCondBr),
        .prevCounter (prevCounter),
        .pushReady   (pushReady),
        .updStall    (updStall),
        .updValid    (updValid),
        .updIndex    (updIndex),
        .updCounter  (updCounter),
        .updTaken    (updTaken),
        .updMispred  (updMispred),
        .updIsCondBr (updIsCondBr),
        .dropCount   (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row: inputs for one cycle and the outputs expected during
    // that cycle (before the edge). idx/ctr are checked only on valid lanes.
    typedef struct {
        bit       r;
        bit       st;
        bit [1:0] bv;
        int       a0;
        int       a1;
        bit [1:0] tk;
        int       p0;
        int       p1;
        bit       er;
        bit [1:0] ev;
        int       i0;
        int       c0;
        int       i1;
        int       c1;
        int       dr;
    } row_t;

    typedef struct {
        int idx;
        int ctr;
        bit tk;
        bit mis;
        bit cond;
    } ent_t;

    row_t rows[$];
    ent_t mq[$];
    int   mdrop;
    int   checks;
    int   errors;

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic addRow(input bit r, input bit st, input bit [1:0] bv,
                          input int a0, input int a1, input bit [1:0] tk,
                          input int p0, input int p1, input bit er,
                          input bit [1:0] ev, input int i0, input int c0,
                          input int i1, input int c1, input int dr);
        row_t x;
        x = '{r, st, bv, a0, a1, tk, p0, p1, er, ev, i0, c0, i1, c1, dr};
        rows.push_back(x);
    endtask

    task automatic applyStimulus(input row_t x, input bit [1:0] mis, input bit [1:0] cnd);
        rst            = x.r;
        updStall       = x.st;
        brValid[0]     = x.bv[0];
        brValid[1]     = x.bv[1];
        brAddr[0]      = x.a0;
        brAddr[1]      = x.a1;
        execTaken[0]   = x.tk[0];
        execTaken[1]   = x.tk[1];
        prevCounter[0] = 2'(x.p0);
        prevCounter[1] = 2'(x.p1);
        mispred[0]     = mis[0];
        mispred[1]     = mis[1];
        isCondBr[0]    = cnd[0];
        isCondBr[1]    = cnd[1];
        #1;
    endtask

    // Reference model: a plain queue of entries. Compares the current
    // outputs, then applies this cycle's pops and pushes and steps the clock.
    task automatic modelStep();
        bit   exp_ready;
        int   npop;
        int   used;
        int   nvalid;
        ent_t e;
        exp_ready = !rst && ((8 - mq.size()) >= 2);
        npop = 0;
        used = 0;
        if (!rst && !updStall) begin
            for (int i = 0; i < 2; i++) begin
                if (i >= mq.size()) break;
                if (used[mq[i].idx % 2]) break;
                used[mq[i].idx % 2] = 1'b1;
                npop++;
            end
        end
        checkOutput("model pushReady", int'(pushReady), int'(exp_ready));
        checkOutput("model dropCount", int'(dropCount), mdrop);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("model updValid[%0d]", i), int'(updValid[i]), int'(i < npop));
            if (!rst && i < mq.size()) begin
                checkOutput($sformatf("model updIndex[%0d]", i), int'(updIndex[i]), mq[i].idx);
                checkOutput($sformatf("model updCounter[%0d]", i), int'(updCounter[i]), mq[i].ctr);
                checkOutput($sformatf("model updTaken[%0d]", i), int'(updTaken[i]), int'(mq[i].tk));
                checkOutput($sformatf("model updMispred[%0d]", i), int'(updMispred[i]), int'(mq[i].mis));
                checkOutput($sformatf("model updIsCondBr[%0d]", i), int'(updIsCondBr[i]), int'(mq[i].cond));
            end
        end
        if (rst) begin
            mq.delete();
            mdrop = 0;
        end else begin
            for (int i = 0; i < npop; i++) void'(mq.pop_front());
            nvalid = 0;
            for (int l = 0; l < 2; l++) begin
                if (brValid[l]) begin
                    nvalid++;
                    e.idx  = int'((brAddr[l] >> 2) % 1024);
                    if (execTaken[l]) e.ctr = (prevCounter[l] == 3) ? 3 : int'(prevCounter[l]) + 1;
                    else              e.ctr = (prevCounter[l] == 0) ? 0 : int'(prevCounter[l]) - 1;
                    e.tk   = execTaken[l];
                    e.mis  = mispred[l];
                    e.cond = isCondBr[l];
                    if (exp_ready) mq.push_back(e);
                end
            end
            if (!exp_ready) mdrop = (mdrop + nvalid > 65535) ? 65535 : mdrop + nvalid;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        row_t x;
        checks = 0;
        errors = 0;
        mdrop  = 0;

        // Bring the design to a known state before any check.
        x = '{1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0};
        applyStimulus(x, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        //     r st bv     a0       a1       tk    p0 p1 er ev     i0 c0 i1 c1 dr
        addRow(1, 0, 2'b00, 0,       0,       2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b01, 'h1000,  0,       2'b01, 2, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b01, 0, 3, 0, 0, 0);
        addRow(0, 0, 2'b11, 'h2004,  'h1000,  2'b01, 3, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b11, 1, 3, 0, 0, 0);
        addRow(0, 0, 2'b11, 'h1000,  'h1008,  2'b11, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b01, 0, 2, 0, 0, 0);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b01, 2, 2, 0, 0, 0);
        addRow(0, 1, 2'b10, 0,       'h3000,  2'b00, 0, 2, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 1, 2'b11, 'h4004,  'h4008,  2'b11, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 1, 2'b11, 'h5000,  'h5004,  2'b11, 2, 2, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 1, 2'b11, 'h6000,  'h6004,  2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 1, 2'b11, 'h7000,  'h7004,  2'b11, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 1, 2'b01, 'h8000,  0,       2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 0, 2'b11, 0, 1, 1, 1, 3);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b01, 2, 1, 0, 0, 3);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b11, 0, 3, 1, 3, 3);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b11, 0, 0, 1, 0, 3);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 3);
        addRow(0, 1, 2'b11, 'h1000,  'h1004,  2'b11, 1, 1, 1, 2'b00, 0, 0, 0, 0, 3);
        addRow(0, 1, 2'b11, 'h1008,  'h100C,  2'b11, 1, 1, 1, 2'b00, 0, 0, 0, 0, 3);
        addRow(0, 1, 2'b01, 'h1010,  0,       2'b11, 1, 1, 1, 2'b00, 0, 0, 0, 0, 3);
        addRow(1, 1, 2'b11, 'h2000,  'h2004,  2'b11, 1, 1, 0, 2'b00, 0, 0, 0, 0, 3);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b10, 0,       'h1004,  2'b10, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
        addRow(0, 0, 2'b00, 0,       0,       2'b00, 0, 0, 1, 2'b01, 1, 2, 0, 0, 0);

        for (int k = 0; k < rows.size(); k++) begin
            applyStimulus(rows[k], rows[k].tk ^ 2'b11, 2'b11);
            checkOutput($sformatf("row%0d pushReady", k), int'(pushReady), int'(rows[k].er));
            checkOutput($sformatf("row%0d dropCount", k), int'(dropCount), rows[k].dr);
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("row%0d updValid[%0d]", k, i), int'(updValid[i]), int'(rows[k].ev[i]));
                if (rows[k].ev[i]) begin
                    checkOutput($sformatf("row%0d updIndex[%0d]", k, i), int'(updIndex[i]),
                                (i == 0) ? rows[k].i0 : rows[k].i1);
                    checkOutput($sformatf("row%0d updCounter[%0d]", k, i), int'(updCounter[i]),
                                (i == 0) ? rows[k].c0 : rows[k].c1);
                end
            end
            modelStep();
        end

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            x.r  = ($urandom_range(0, 99) == 0);
            x.st = ($urandom_range(0, 3) == 0);
            x.bv = 2'($urandom);
            x.a0 = int'(($urandom & 32'hFFFF_F000) | ($urandom_range(0, 7) << 2));
            x.a1 = int'(($urandom & 32'hFFFF_F000) | ($urandom_range(0, 7) << 2));
            x.tk = 2'($urandom);
            x.p0 = $urandom_range(0, 3);
            x.p1 = $urandom_range(0, 3);
            applyStimulus(x, 2'($urandom), 2'($urandom));
            modelStep();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
